// File: rtl/run_progress_timer.sv
// Step/row progress timer: a prescaler paces steps, steps fill columns, columns fill rows.
// Ticks, indices and running are registered so they change together on the completing edge.
module run_progress_timer #(
    parameter int STEP_CYCLES = 10000,
    parameter int COLS        = 30,
    parameter int ROWS        = 10,
    parameter bit ONESHOT     = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic                                  enable,
    output logic                                  step_tick,
    output logic                                  row_tick,
    output logic                                  done,
    output logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] col,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] row,
    output logic                                  running
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [PW-1:0] PMAX = PW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            presc     <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            step_tick <= 1'b0;
            row_tick  <= 1'b0;
            done      <= 1'b0;
            col       <= '0;
            row       <= '0;
            running   <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            row_tick  <= 1'b0;
            done      <= 1'b0;
            if (stop) begin
                state   <= S_IDLE;
                presc   <= '0;
                col_cnt <= '0;
                row_cnt <= '0;
                col     <= '0;
                row     <= '0;
                running <= 1'b0;
            end else if (start) begin
                state   <= S_RUN;
                presc   <= '0;
                col_cnt <= '0;
                row_cnt <= '0;
                col     <= '0;
                row     <= '0;
                running <= 1'b1;
            end else begin
                unique case (state)
                    S_RUN: begin
                        if (enable) begin
                            if (presc == PMAX) begin
                                presc     <= '0;
                                step_tick <= 1'b1;
                                col       <= col_cnt;
                                row       <= row_cnt;
                                if (col_cnt == CMAX) begin
                                    col_cnt  <= '0;
                                    row_tick <= 1'b1;
                                    if (row_cnt == RMAX) begin
                                        row_cnt <= '0;
                                        done    <= 1'b1;
                                        // running stays high through the done pulse
                                        if (ONESHOT) begin
                                            state <= S_DONE;
                                        end
                                    end else begin
                                        row_cnt <= row_cnt + 1'b1;
                                    end
                                end else begin
                                    col_cnt <= col_cnt + 1'b1;
                                end
                            end else begin
                                presc <= presc + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        running <= 1'b0;
                    end
                    default: begin
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/run_progress_timer.md
RUN_PROGRESS_TIMER -- requirements
Module: run_progress_timer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 10000: enabled clock cycles per step, legal range 1 to 2^24.
REQ-002 SHALL have parameter COLS, default 30: steps per row, legal range 1 to 256.
REQ-003 SHALL have parameter ROWS, default 10: rows per run, legal range 1 to 256.
REQ-004 SHALL have parameter ONESHOT, default 1: 1 = stop at end of run; 0 = wrap and continue.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin a run from IDLE or DONE.
REQ-008 SHALL have port stop, input, 1 bit: abort and return to IDLE.
REQ-009 SHALL have port enable, input, 1 bit: when low in RUN, the timer pauses.
REQ-010 SHALL have port step_tick, output, 1 bit: one-cycle pulse at each completed step.
REQ-011 SHALL have port row_tick, output, 1 bit: one-cycle pulse when a row's last step completes.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the final step of the final row completes.
REQ-013 SHALL have port col, output, max(1,clog2(COLS)) bits: column index of the step just completed.
REQ-014 SHALL have port row, output, max(1,clog2(ROWS)) bits: row index of the step just completed.
REQ-015 SHALL have port running, output, 1 bit: high while in RUN.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE, encoded internally.
REQ-017 SHALL transition IDLE->RUN or DONE->RUN on start=1; the prescaler, column counter and row counter clear on the same edge.
REQ-018 SHALL transition any state->IDLE on stop=1; stop beats start when both are asserted; the counters clear.
REQ-019 SHALL, when start=1 in RUN, restart the run with the counters cleared, emitting no tick on that edge.
REQ-020 SHALL, in RUN with enable=1, increment the prescaler each cycle; at STEP_CYCLES-1 the prescaler wraps to 0 and a step completes.
REQ-021 SHALL, in RUN with enable=0, hold the prescaler and all counters; ticks stay low.
REQ-022 SHALL register step_tick, col and row on the completing edge, so the first step_tick is high exactly STEP_CYCLES enabled RUN cycles after the start edge.
REQ-023 SHALL drive col/row to the index of the completed step and hold them until the next step completes.
REQ-024 SHALL, at a column wrap (COLS-1 -> 0), assert row_tick together with step_tick and advance the row counter.
REQ-025 SHALL, when the step completing at col=COLS-1 and row=ROWS-1 occurs, assert step_tick, row_tick and done together.
REQ-026 SHALL, after done, enter DONE if ONESHOT=1, and stay in RUN with the counters wrapped to 0 if ONESHOT=0.
REQ-027 SHALL, with STEP_CYCLES=1, produce step_tick on every enabled RUN cycle.
REQ-028 SHALL, with COLS=1, assert row_tick on every step_tick; with ROWS=1 and COLS=1, assert done on every step.
REQ-029 SHALL size every counter for the maximum value of its parameter, with no overflow at any legal parameter value.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, enter IDLE and clear the prescaler and counters.
REQ-031 SHALL hold all of step_tick, row_tick, done, col, row and running at 0 from the first edge with reset=1.
REQ-032 SHALL let reset beat start and stop, including reset asserted mid-run.

Verification (STEP_CYCLES=4, COLS=3, ROWS=2 unless stated)
REQ-033 SHALL cover the basic run: start pulse, enable=1 -> step_tick at cycles 4,8,...,24; col sequence 0,1,2,0,1,2; row_tick at 12 and 24; done at 24; running=0 from 25.
REQ-034 SHALL cover pause: enable=0 for 5 cycles mid-step -> every later tick is delayed by exactly 5 cycles, with no lost or extra tick.
REQ-035 SHALL cover stop mid-run: stop at cycle 10 -> IDLE; no further ticks; the next start gives its first tick 4 cycles later with col=0, row=0.
REQ-036 SHALL cover free-running mode: ONESHOT=0 -> done at 24 and 48; col=0, row=0 tick at 28; running stays 1.
REQ-037 SHALL cover reset mid-run: reset at cycle 7 -> all outputs 0 the next cycle; start with reset=1 is ignored.
REQ-038 SHALL cover the degenerate case: STEP_CYCLES=1, COLS=1, ROWS=1, ONESHOT=0 -> step_tick, row_tick and done high on every enabled cycle after start.
